// File: rtl/mips_fetch_pkg.sv
// Shared state type and instruction-field constants for the MIPS fetch stage.
package mips_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } fetch_state_t;

    localparam int OP_MSB = 31;
    localparam int OP_W   = 6;
    localparam int REG_W  = 5;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int IMM_W  = 16;
    localparam int JT_W   = 26;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Parametrised synchronous FIFO holding prefetched {address, word} entries.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign rdata     = mem_r[rd_ptr_r];
    assign do_push_s = push && !full && !flush;
    assign do_pop_s  = pop && !empty && !flush;

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; flush wins over any push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding req/gnt/rvalid fetch FSM,
// prefetch FIFO and field split. Build macro FETCH_MISALIGN_CHECK_EN adds misalign_err.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic              misalign_err,
`endif
    input  logic              Clk,
    input  logic              Reset,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [5:0]        Instr31_26,
    output logic [4:0]        Instr25_21,
    output logic [4:0]        Instr20_16,
    output logic [4:0]        Instr15_11,
    output logic [15:0]       Instr15_0,
    output logic [25:0]       Instr25_0
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = ADDR_W + DATA_W;

    fetch_state_t      state_r;
    fetch_state_t      state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_s;
    logic [ADDR_W-1:0] fetch_addr_r;
    logic [ADDR_W-1:0] fetch_addr_s;
    logic              redirect_s;
    logic [ADDR_W-1:0] target_s;
    logic              push_s;
    logic              pop_s;
    logic              flush_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [ENT_W-1:0]  fifo_wdata_s;
    logic [ENT_W-1:0]  fifo_rdata_s;
    logic [DATA_W-1:0] head_word_s;
    logic [ADDR_W-1:0] head_pc_s;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_r;

    assign redirect_s   = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign target_s     = redirect_pc;
    assign misalign_err = misalign_r;

    // Sticky flag for rejected misaligned redirects
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            misalign_r <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_r <= 1'b1;
        end
    end
`else
    assign redirect_s = redirect_valid;
    assign target_s   = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
`endif

    assign mem_req      = (state_r == REQ);
    assign mem_addr     = pc_r;
    assign out_valid    = !fifo_empty_s;
    assign pop_s        = !fifo_empty_s && out_ready;
    assign fifo_wdata_s = {fetch_addr_r, mem_rdata};
    assign head_pc_s    = fifo_rdata_s[ENT_W-1:DATA_W];
    assign head_word_s  = fifo_rdata_s[DATA_W-1:0];

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (flush_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // State, PC and in-flight fetch address registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r      <= IDLE;
            pc_r         <= RESET_PC;
            fetch_addr_r <= RESET_PC;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            fetch_addr_r <= fetch_addr_s;
        end
    end

    // Next-state, PC update and FIFO push/flush; redirect overrides everything
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        fetch_addr_s = fetch_addr_r;
        push_s       = 1'b0;
        flush_s      = 1'b0;
        if (redirect_s) begin
            flush_s = 1'b1;
            pc_s    = target_s;
        end else begin
            flush_s = 1'b0;
        end
        case (state_r)
            IDLE: begin
                state_s = REQ;
            end
            REQ: begin
                if (redirect_s) begin
                    state_s = mem_gnt ? DROP : REQ;
                end else if (mem_gnt) begin
                    pc_s         = pc_r + ADDR_W'(PC_STEP);
                    fetch_addr_s = pc_r;
                    state_s      = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (redirect_s) begin
                    // Data landing in the redirect cycle is simply not pushed
                    state_s = mem_rvalid ? REQ : DROP;
                end else if (mem_rvalid) begin
                    push_s  = 1'b1;
                    state_s = (pop_s || (fifo_count_s < CNT_W'(DEPTH - 1))) ? REQ : HOLD;
                end else begin
                    state_s = WAIT;
                end
            end
            HOLD: begin
                if (redirect_s || pop_s || !fifo_full_s) begin
                    state_s = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            DROP: begin
                // A redirect here only retargets the PC; the stale response is still owed
                state_s = mem_rvalid ? REQ : DROP;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Split the head word into fields; all zero while nothing is presented
    always_comb begin
        out_pc     = {ADDR_W{1'b0}};
        Instr31_26 = 6'h00;
        Instr25_21 = 5'h00;
        Instr20_16 = 5'h00;
        Instr15_11 = 5'h00;
        Instr15_0  = 16'h0000;
        Instr25_0  = 26'h000_0000;
        if (fifo_empty_s) begin
            out_pc = {ADDR_W{1'b0}};
        end else begin
            out_pc     = head_pc_s;
            Instr31_26 = head_word_s[OP_MSB -: OP_W];
            Instr25_21 = head_word_s[RS_LSB +: REG_W];
            Instr20_16 = head_word_s[RT_LSB +: REG_W];
            Instr15_11 = head_word_s[RD_LSB +: REG_W];
            Instr15_0  = head_word_s[IMM_W-1:0];
            Instr25_0  = head_word_s[JT_W-1:0];
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench for mips_fetch_unit: memory responder plus an
// instruction-stream reference model (sequential PCs restarting at each redirect target).
module tb_mips_fetch_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [5:0]  Instr31_26;
    logic [4:0]  Instr25_21;
    logic [4:0]  Instr20_16;
    logic [4:0]  Instr15_11;
    logic [15:0] Instr15_0;
    logic [25:0] Instr25_0;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
    logic        exp_err = 1'b0;
`endif

    mips_fetch_unit dut (
`ifdef FETCH_MISALIGN_CHECK_EN
        .misalign_err   (misalign_err),
`endif
        .Clk            (Clk),
        .Reset          (Reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .Instr31_26     (Instr31_26),
        .Instr25_21     (Instr25_21),
        .Instr20_16     (Instr20_16),
        .Instr15_11     (Instr15_11),
        .Instr15_0      (Instr15_0),
        .Instr25_0      (Instr25_0)
    );

    always #5 Clk = ~Clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          pops = 0;
    logic [31:0] exp_pc = 32'h0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    // memory responder knobs and record of granted addresses
    int          gnt_pct = 100;
    int          lat_min = 0;
    int          lat_max = 0;
    bit          pend = 1'b0;
    int          pend_lat = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] gnt_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2009_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Memory: decide gnt/rvalid at the falling edge for the next rising edge
    always @(negedge Clk) begin
        if (!Reset) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            pend       = 1'b0;
        end else begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (pend) begin
                if (pend_lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(pend_addr);
                    pend       = 1'b0;
                end else begin
                    pend_lat = pend_lat - 1;
                end
            end
            if (mem_req && !pend && !mem_rvalid && ($urandom_range(99, 0) < gnt_pct)) begin
                mem_gnt   = 1'b1;
                pend      = 1'b1;
                pend_addr = mem_addr;
                pend_lat  = $urandom_range(lat_max, lat_min);
                gnt_q.push_back(mem_addr);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gnt_at(input int idx);
        if (idx < gnt_q.size()) return gnt_q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // Check the current cycle against the model, then advance one clock
    task automatic tick();
        logic [31:0] w;
        if (Reset) begin
            if (out_valid && out_ready) begin
                w = mem_word(exp_pc);
                chk("pop_pc", 64'(out_pc), 64'(exp_pc));
                chk("pop_fields",
                    64'({Instr31_26, Instr25_21, Instr20_16, Instr15_11, Instr15_0, Instr25_0}),
                    64'({w[31:26], w[25:21], w[20:16], w[15:11], w[15:0], w[25:0]}));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (prev_hold && mem_req) chk("addr_stable", 64'(mem_addr), 64'(prev_addr));
            prev_hold = mem_req && !mem_gnt && !redirect_valid;
            prev_addr = mem_addr;
            if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                if (redirect_pc[1:0] == 2'b00) exp_pc = redirect_pc;
                else exp_err = 1'b1;
`else
                exp_pc = {redirect_pc[31:2], 2'b00};
`endif
            end
        end else begin
            prev_hold = 1'b0;
        end
        @(posedge Clk);
        @(negedge Clk);
        #2;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) ok = out_valid;
    endtask

    task automatic hold_reset();
        Reset          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        exp_pc         = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
        exp_err        = 1'b0;
`endif
        gnt_q.delete();
        repeat (3) tick();
    endtask

    initial begin
        bit ok;
        int n;
        int rand_pops;
        @(negedge Clk);
        #2;

        // 1: reset values, IDLE cycle, first decoded instruction
        chk("rst_req", 64'(mem_req), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        chk("rst_fields", 64'({Instr31_26, Instr25_21, Instr20_16, Instr15_11, Instr15_0, Instr25_0}), 64'd0);
        repeat (2) tick();
        out_ready = 1'b1;
        Reset = 1'b1;
        chk("idle_req", 64'(mem_req), 64'd0);
        tick();
        chk("req_after_idle", 64'(mem_req), 64'd1);
        chk("first_addr", 64'(mem_addr), 64'd0);
        wait_valid(20, ok);
        chk("t1_timeout", 64'(ok), 64'd1);
        chk("t1_pc", 64'(out_pc), 64'd0);
        chk("t1_op", 64'(Instr31_26), 64'h08);
        chk("t1_rs", 64'(Instr25_21), 64'd0);
        chk("t1_rt", 64'(Instr20_16), 64'd9);
        chk("t1_imm", 64'(Instr15_0), 64'h0005);
        tick();
        wait_valid(20, ok);
        chk("t1_timeout2", 64'(ok), 64'd1);
        chk("t1_pc2", 64'(out_pc), 64'h4);

        // 2: reset mid-transaction, then fill the FIFO with no consumer
        Reset = 1'b0;
        #1;
        chk("mid_rst_req", 64'(mem_req), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_addr", 64'(mem_addr), 64'd0);
        #1;
        hold_reset();
        Reset = 1'b1;
        repeat (30) tick();
        chk("t2_gnt_count", 64'(gnt_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t2_gnt_addr", 64'(gnt_at(i)), 64'(i * 4));
        chk("t2_req_idle", 64'(mem_req), 64'd0);
        chk("t2_head", 64'(out_pc), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        repeat (20) tick();
        chk("t2_gnt_count2", 64'(gnt_q.size()), 64'd5);
        chk("t2_gnt_refill", 64'(gnt_at(4)), 64'h10);

        // 3: redirect while waiting; stale data arrives three cycles later
        hold_reset();
        Reset = 1'b1;
        out_ready = 1'b1;
        lat_min = 3;
        lat_max = 3;
        for (int i = 0; i < 20; i++) begin
            if (mem_gnt) break;
            tick();
        end
        chk("t3_gnt_seen", 64'(mem_gnt), 64'd1);
        tick();
        n = gnt_q.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        lat_min = 0;
        lat_max = 0;
        wait_valid(40, ok);
        chk("t3_timeout", 64'(ok), 64'd1);
        chk("t3_first_pc", 64'(out_pc), 64'h400);
        chk("t3_next_addr", 64'(gnt_at(n)), 64'h400);
        repeat (10) tick();

        // 4: redirect in the same cycle as a pop of head pc=8
        hold_reset();
        Reset = 1'b1;
        repeat (20) tick();
        out_ready = 1'b1;
        repeat (2) tick();
        chk("t4_head", 64'(out_pc), 64'h8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        chk("t4_flushed", 64'(out_valid), 64'd0);
        wait_valid(20, ok);
        chk("t4_timeout", 64'(ok), 64'd1);
        chk("t4_target", 64'(out_pc), 64'h200);
        repeat (5) tick();

        // 5: PC wrap at the top of the address space
        n = gnt_q.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        chk("t5_top", 64'(gnt_at(n)), 64'hFFFF_FFFC);
        chk("t5_wrap", 64'(gnt_at(n + 1)), 64'h0);

        // 6: misaligned redirect target
        n = gnt_q.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h402;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("t6_err", 64'(misalign_err), 64'd1);
        chk("t6_seq", 64'(gnt_at(n)), 64'(gnt_at(n - 1) + 32'd4));
`else
        chk("t6_aligned", 64'(gnt_at(n)), 64'h400);
`endif

        // 7: randomized traffic, latency, backpressure and redirects
        gnt_pct = 70;
        lat_min = 0;
        lat_max = 3;
        rand_pops = pops;
        for (int c = 0; c < 1500; c++) begin
            out_ready = ($urandom_range(3, 0) != 0);
            redirect_valid = ($urandom_range(99, 0) < 3);
            redirect_pc = $urandom;
            tick();
        end
        redirect_valid = 1'b0;
        chk("rand_progress", 64'((pops - rand_pops) > 100), 64'd1);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rand_err", 64'(misalign_err), 64'(exp_err));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

endmodule
